// File: rtl/toggle_req_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_req_responder_pkg
// Brief    : Shared state encoding and default parameters for the toggle
//            request responder and its synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
package toggle_req_responder_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/toggle_req_responder_bit_sync.sv
`default_nettype none
// ============================================================================
// Module   : bit_sync
// Brief    : N-stage single-bit synchronizer for a level that may change
//            asynchronously to clk. STAGES must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the incoming level one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain registers; cleared asynchronously so the crossing restarts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/toggle_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : toggle_req_responder
// Brief    : Receiving end of a two-phase toggle handshake. Each flip of the
//            synchronized request becomes one valid/ready event; acceptance
//            flips the acknowledge toggle and bumps a wrapping counter. A
//            request flip that cancels a still-pending event sets a sticky
//            error flag.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_req_responder
  import toggle_req_responder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_tog,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ack_tog,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             err,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             req_s;
  state_e           state_q, state_d;
  logic             ack_q,   ack_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;
  logic             err_set;

  // req_tog is only ever observed through this synchronizer.
  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_tog),
    .q     (req_s)
  );

  // Next-state, acknowledge, counter and error-set decisions.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s != ack_q) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // Acceptance wins over a simultaneous cancel, but the cancel is
        // still reported as an error.
        if (evt_ready) begin
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ST_IDLE;
        end
        if (req_s == ack_q) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A new error on the same edge as a clear keeps the flag set.
    err_d = err_set | (err_q & ~err_clr);
  end

  // State, acknowledge, counter and error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from registers; no path from evt_ready.
  assign evt_valid = (state_q == ST_PEND);
  assign ack_tog   = ack_q;
  assign evt_cnt   = cnt_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/toggle_req_responder.md
Name: toggle_req_responder

Overview:
- Receiving end of the two-phase toggle handshake. The sender side is built on the team's T flip-flop: each request event flips `req_tog`.
- This block synchronizes `req_tog` and detects each flip.
- It presents each flip as one valid/ready event to downstream logic and flips `ack_tog` back when the event is accepted.
- It keeps a wrapping event count and a sticky lost-event error flag.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth on req_tog (legal values 2..4)
- CNT_W, 8, width of the accepted-event counter

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_tog  in  1  request toggle from the sender; may be asynchronous to clk
- evt_valid  out  1  event pending toward downstream
- evt_ready  in  1  downstream accepts the pending event
- ack_tog  out  1  acknowledge toggle back to the sender
- evt_cnt  out  CNT_W  count of accepted events
- err  out  1  sticky flag: a request toggle arrived while an event was still pending
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async assert, sync release): sync chain all 0, state IDLE, evt_valid 0, ack_tog 0, evt_cnt 0, err 0.
- Synchronizer: a SYNC_STAGES-deep flop chain produces req_s. req_s is the only use of req_tog; no logic reads req_tog directly.
- State machine, 2 states, registered:
  - IDLE: if req_s != ack_tog, go to PEND; else stay.
  - PEND, on evt_ready=1: ack_tog flips, evt_cnt increments, go to IDLE.
  - PEND, on req_s == ack_tog (sender toggled again before acceptance): event lost. err is set, go to IDLE; ack_tog and evt_cnt are unchanged.
  - PEND, on both at the same edge: acceptance wins. ack_tog flips, evt_cnt increments, err is set.
- evt_valid = (state == PEND), decoded from the state register only; no combinational path from evt_ready.
- Latency: a req_tog flip first sampled at edge E0 gives evt_valid=1 after edge E0+SYNC_STAGES (edge E0+2 for the default).
- Handshake: a transfer occurs on any edge with evt_valid & evt_ready. evt_valid drops after that edge. The earliest re-assertion is after the next edge, and only if req_s has flipped again.
- Sender rule: the sender flips req_tog only when req_tog == ack_tog (as seen in the sender's domain). The responder does not rely on this rule; violations are caught via err.
- evt_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- err: set and err_clr on the same edge leaves err=1 (set wins). err_clr alone clears err on the next edge.
- Reset mid-operation:
  - A pending event is dropped and not counted.
  - If req_tog is 1 at reset release, req_s becomes 1 while ack_tog=0, giving one event. This is intended.
  - The sender and responder must share a reset so that both toggles restart at 0.
- evt_ready while IDLE is ignored.

Decomposition:
- Shared package: state enum (ST_IDLE, ST_PEND) and the default constants SYNC_STAGES_DEF=2 and CNT_W_DEF=8.
- One sub-module: bit_sync, a parameterized N-stage single-bit synchronizer with clk and reset. It is reused by any later toggle-based crossing.
- The FSM, ack register, counter and err logic stay in the top module.

Test Plan:
- Reset: assert reset mid-cycle with req_tog=1.
  - While reset is high: all outputs are 0 immediately and asynchronously.
  - After release: evt_valid=1 at the 3rd edge, evt_cnt=0.
- Single event, evt_ready held 1: req_tog 0->1.
  - evt_valid is high for exactly one cycle, 2 edges after the sample.
  - ack_tog becomes 1 and evt_cnt becomes 1 at the acceptance edge.
- Backpressure: evt_ready=0 for 5 cycles after req_tog flips.
  - evt_valid stays 1 and ack_tog does not change.
  - Raising evt_ready gives a transfer on that edge; evt_cnt increments by 1.
- Lost event: with evt_ready=0, flip req_tog 0->1, then 1->0 three cycles later.
  - evt_valid drops, err=1, evt_cnt unchanged, ack_tog=0.
  - Pulsing err_clr then clears err; err_clr on the same edge as a new error leaves err=1.
- Wrap (CNT_W=4): run 17 fully handshaken events with the sender obeying its rule. Expect evt_cnt 15 after event 15, 0 after event 16, 1 after event 17, and err=0 throughout.
- Randomized sender obeying its rule, random evt_ready duty over 1000 events: evt_cnt equals the number of sender flips mod 2^CNT_W, and err never sets.
